// File: rtl/inst_mem_resp_pkg.sv
// Shared definitions for the instruction-side memory responder.
package inst_mem_resp_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord    = '0;
  localparam logic [InstBus-1:0] NopInst     = '0;
  localparam logic               ChipEnable  = 1'b1;
  localparam logic               ChipDisable = 1'b0;
  localparam logic               RstEnable   = 1'b1;

  // A fetch faults when it is not word aligned or lies beyond the store.
  function automatic logic fetch_fault(input logic [InstAddrBus-1:0] a,
                                       input int unsigned aw);
    return (a[1:0] != 2'b00) || ((a >> (aw + 2)) != ZeroWord);
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Instruction store: DEPTH x 32, one synchronous write and one synchronous read port.
module inst_mem_array #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/inst_mem_resp.sv
// Instruction memory responder: serves 1-cycle fetches once a word-serial load
// has filled the store; fetches are suppressed while empty or loading.
module inst_mem_resp
  import inst_mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [InstAddrBus-1:0] addr,
  output logic [InstBus-1:0]     inst,
  output logic                   inst_valid,
  output logic                   fault,
  input  logic                   ld_start,
  input  logic                   ld_valid,
  input  logic [InstBus-1:0]     ld_data,
  input  logic                   ld_last,
  output logic                   ld_ready,
  output logic                   ld_done
);

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              hit;
  logic              bad;
  logic              re;
  logic              we;
  logic [31:0]       rdata;

  assign bad      = fetch_fault(addr, ADDR_W);
  assign re       = (rst != RstEnable) && (state == READY) && (ce == ChipEnable) && !bad;
  assign we       = (rst != RstEnable) && (state == LOAD) && ld_valid;
  assign ld_ready = (state == LOAD);

  // The array output has no reset, so the registered hit flag gates it onto inst.
  assign inst = hit ? rdata : NopInst;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state      <= EMPTY;
      ptr        <= '0;
      hit        <= 1'b0;
      inst_valid <= 1'b0;
      fault      <= 1'b0;
      ld_done    <= 1'b0;
    end else begin
      ld_done <= 1'b0;

      if (state == READY && ce != ChipDisable) begin
        inst_valid <= 1'b1;
        fault      <= bad;
        hit        <= !bad;
      end else begin
        inst_valid <= 1'b0;
        fault      <= 1'b0;
        hit        <= 1'b0;
      end

      unique case (state)
        EMPTY: begin
          if (ld_start) begin
            state <= LOAD;
            ptr   <= '0;
          end
        end
        LOAD: begin
          if (ld_valid) begin
            if (ld_last || (&ptr)) begin
              state   <= READY;
              ld_done <= 1'b1;
              ptr     <= '0;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        READY: begin
          if (ld_start) begin
            state <= LOAD;
            ptr   <= '0;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  inst_mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (ptr),
    .wdata (ld_data),
    .re    (re),
    .raddr (addr[ADDR_W+1:2]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_inst_mem_resp.sv
// Self-checking bench for inst_mem_resp: behavioural store model plus directed literals.
module tb_inst_mem_resp;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int M_EMPTY = 0;
  localparam int M_LOAD  = 1;
  localparam int M_READY = 2;

  logic        clk = 1'b0;
  logic        rst, ce, ld_start, ld_valid, ld_last;
  logic [31:0] addr, ld_data;
  logic [31:0] inst;
  logic        inst_valid, fault, ld_ready, ld_done;

  int checks = 0;
  int errors = 0;

  inst_mem_resp #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .addr       (addr),
    .inst       (inst),
    .inst_valid (inst_valid),
    .fault      (fault),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done)
  );

  always #5 clk = ~clk;

  // Behavioural model: a word array, a load cursor and a mode.
  logic [31:0] mm [DEPTH];
  int          mode    = M_EMPTY;
  int          lptr    = 0;
  bit          started = 1'b0;
  logic [31:0] e_inst  = '0;
  logic        e_valid = 1'b0, e_fault = 1'b0, e_done = 1'b0;

  initial for (int i = 0; i < DEPTH; i++) mm[i] = '0;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      mode = M_EMPTY; lptr = 0;
      e_inst = '0; e_valid = 1'b0; e_fault = 1'b0; e_done = 1'b0;
    end else begin
      if (mode == M_READY && ce) begin
        e_valid = 1'b1;
        if ((addr % 4) != 0 || addr >= 4 * DEPTH) begin
          e_fault = 1'b1; e_inst = '0;
        end else begin
          e_fault = 1'b0; e_inst = mm[addr / 4];
        end
      end else begin
        e_valid = 1'b0; e_fault = 1'b0; e_inst = '0;
      end
      e_done = 1'b0;
      if (mode == M_LOAD) begin
        if (ld_valid) begin
          mm[lptr] = ld_data;
          if (ld_last || lptr == DEPTH - 1) begin
            mode = M_READY; e_done = 1'b1;
          end
          lptr++;
        end
      end else if (ld_start) begin
        mode = M_LOAD; lptr = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (inst !== e_inst || inst_valid !== e_valid || fault !== e_fault ||
          ld_ready !== (mode == M_LOAD) || ld_done !== e_done) begin
        errors++;
        $display("FAIL cycle t=%0t actual inst=%h v=%b f=%b rdy=%b done=%b required inst=%h v=%b f=%b rdy=%b done=%b",
                 $time, inst, inst_valid, fault, ld_ready, ld_done,
                 e_inst, e_valid, e_fault, (mode == M_LOAD), e_done);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fetch(input logic [31:0] a);
    ce = 1'b1; addr = a;
    cyc();
  endtask

  task automatic full_load(input logic [31:0] base);
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 32'hDEADBEEF; ld_last = 1'b0;
    cyc();
    ld_start = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ld_valid = 1'b1; ld_data = base + i;
      ld_start = (i == 500);
      cyc();
    end
    ld_valid = 1'b0; ld_start = 1'b0;
    chk("auto_done", {31'b0, ld_done}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; addr = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    cyc(); cyc();
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_ready", {31'b0, ld_ready}, 32'd0);
    rst = 1'b0;
    fetch(32'h0);
    chk("empty_valid", {31'b0, inst_valid}, 32'd0);
    chk("empty_ready", {31'b0, ld_ready}, 32'd0);

    ld_start = 1'b1; ce = 1'b0;
    cyc();
    ld_start = 1'b0;
    chk("load_ready", {31'b0, ld_ready}, 32'd1);
    for (int unsigned i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = (i + 1) * 32'h11111111; ld_last = (i == 3);
      cyc();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("done_pulse", {31'b0, ld_done}, 32'd1);
    fetch(32'h0);
    chk("done_once", {31'b0, ld_done}, 32'd0);
    chk("word0", inst, 32'h11111111);
    chk("word0_valid", {31'b0, inst_valid}, 32'd1);
    fetch(32'h4); chk("word1", inst, 32'h22222222);
    fetch(32'h8); chk("word2", inst, 32'h33333333);
    fetch(32'hC); chk("word3", inst, 32'h44444444);

    fetch(32'h6);
    chk("mis_fault", {31'b0, fault}, 32'd1);
    chk("mis_inst", inst, 32'h0);
    chk("mis_valid", {31'b0, inst_valid}, 32'd1);
    fetch(32'h1000);
    chk("oor_fault", {31'b0, fault}, 32'd1);

    fetch(32'h4); chk("ce1_valid", {31'b0, inst_valid}, 32'd1);
    ce = 1'b0; cyc();
    chk("ce0_valid", {31'b0, inst_valid}, 32'd0);
    chk("ce0_inst", inst, 32'h0);
    fetch(32'h4); chk("ce1b_inst", inst, 32'h22222222);

    ce = 1'b0;
    full_load(32'hC0DE0000);
    fetch(32'hFFC); chk("last_word", inst, 32'hC0DE03FF);
    fetch(32'h0);   chk("first_word", inst, 32'hC0DE0000);

    ce = 1'b0; ld_start = 1'b1;
    cyc();
    ld_start = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = 32'h0BAD0000 + i; rst = (i == 2);
      cyc();
    end
    rst = 1'b0; ld_valid = 1'b0;
    chk("abort_ready", {31'b0, ld_ready}, 32'd0);
    fetch(32'h8);
    chk("abort_valid", {31'b0, inst_valid}, 32'd0);

    ce = 1'b0; ld_start = 1'b1;
    cyc();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 32'h77777777; ld_last = 1'b1;
    cyc();
    ld_valid = 1'b0; ld_last = 1'b0;
    fetch(32'h0); chk("short_word0", inst, 32'h77777777);
    fetch(32'h4); chk("partial_word1", inst, 32'h0BAD0001);
    fetch(32'h8); chk("unwritten_word2", inst, 32'hC0DE0002);

    ce = 1'b0;
    full_load(32'hF0000000);
    fetch(32'h4);   chk("over_word1", inst, 32'hF0000001);
    fetch(32'h8);   chk("over_word2", inst, 32'hF0000002);
    fetch(32'hFFC); chk("over_last", inst, 32'hF00003FF);
    ce = 1'b0; cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
